// File: rtl/alu_1bit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_1bit
//  Purpose  : Bit-slice ALU (AND / OR / ADD-with-carry / XOR) with a
//             registered result, carry-out and valid. WIDTH > 1 chains
//             identical slices into a ripple-carry word.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_1bit #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             F1,
  input  logic             F0,
  input  logic             VIN,
  output logic [WIDTH-1:0] RES,
  output logic             COUT,
  output logic             VOUT
);

  // Function select encodings
  localparam logic [1:0] c_FN_AND = 2'b00;
  localparam logic [1:0] c_FN_OR  = 2'b01;
  localparam logic [1:0] c_FN_ADD = 2'b10;
  localparam logic [1:0] c_FN_XOR = 2'b11;

  logic [WIDTH:0]   w_carry;   // w_carry[i] is the carry into slice i
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic [1:0]       w_fn;

  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_vout;

  assign w_fn       = {F1, F0};
  assign w_carry[0] = CIN;

  // One full-adder slice per bit; carry ripples from bit 0 upward
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      assign w_sum[i]     = A[i] ^ B[i] ^ w_carry[i];
      assign w_carry[i+1] = (A[i] & B[i]) | (A[i] & w_carry[i]) | (B[i] & w_carry[i]);
    end
  endgenerate

  // Select the combinational result; carry-out is only meaningful for ADD
  always_comb begin
    w_res  = A & B;
    w_cout = 1'b0;
    case (w_fn)
      c_FN_AND: w_res = A & B;
      c_FN_OR:  w_res = A | B;
      c_FN_ADD: begin
        w_res  = w_sum;
        w_cout = w_carry[WIDTH];
      end
      c_FN_XOR: w_res = A ^ B;
      default:  w_res = A & B;
    endcase
  end

  // Output register: reset dominates, result loads only on valid input
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_res  <= '0;
      r_cout <= 1'b0;
      r_vout <= 1'b0;
    end else begin
      r_vout <= VIN;
      if (VIN) begin
        r_res  <= w_res;
        r_cout <= w_cout;
      end
    end
  end

  assign RES  = r_res;
  assign COUT = r_cout;
  assign VOUT = r_vout;

endmodule
`default_nettype wire

// File: tb/tb_alu_1bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_1bit
//  Purpose  : Self-checking bench for alu_1bit at WIDTH=1 and WIDTH=4,
//             compared against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_1bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, cin, f1, f0, vin;
  logic       a1, b1;
  logic [3:0] a4, b4;
  logic       res1, cout1, vout1;
  logic [3:0] res4;
  logic       cout4, vout4;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic       e_res1, e_cout1, e_vout;
  logic [3:0] e_res4;
  logic       e_cout4;

  alu_1bit #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RSTN(rstn), .A(a1), .B(b1), .CIN(cin), .F1(f1), .F0(f0),
    .VIN(vin), .RES(res1), .COUT(cout1), .VOUT(vout1)
  );

  alu_1bit #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RSTN(rstn), .A(a4), .B(b4), .CIN(cin), .F1(f1), .F0(f0),
    .VIN(vin), .RES(res4), .COUT(cout4), .VOUT(vout4)
  );

  // Arithmetic reference: returns {cout, res[3:0]} for a w-bit operation
  function automatic logic [4:0] ref_alu(input int w, input logic [3:0] a,
                                         input logic [3:0] b, input logic c,
                                         input logic [1:0] f);
    logic [31:0] mask, av, bv, r, s, co;
    mask = (32'd1 << w) - 32'd1;
    av   = {28'd0, a} & mask;
    bv   = {28'd0, b} & mask;
    co   = 32'd0;
    case (f)
      2'b00:   r = av & bv;
      2'b01:   r = av | bv;
      2'b11:   r = av ^ bv;
      default: begin
        s  = av + bv + {31'd0, c};
        r  = s & mask;
        co = (s >> w) & 32'd1;
      end
    endcase
    return {co[0], r[3:0]};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs for one clock edge, advance model, check all outputs
  task automatic step(input logic r, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input logic [1:0] f);
    logic [4:0] m1, m4;
    @(negedge clk);
    rstn = r; vin = v; a4 = a; b4 = b; a1 = a[0]; b1 = b[0];
    cin = c; f1 = f[1]; f0 = f[0];
    m1 = ref_alu(1, a, b, c, f);
    m4 = ref_alu(4, a, b, c, f);
    @(posedge clk);
    #1;
    if (!r) begin
      e_res1 = 1'b0; e_cout1 = 1'b0; e_res4 = 4'h0; e_cout4 = 1'b0; e_vout = 1'b0;
    end else begin
      e_vout = v;
      if (v) begin
        e_res1 = m1[0]; e_cout1 = m1[4]; e_res4 = m4[3:0]; e_cout4 = m4[4];
      end
    end
    check("res1",  {4'd0, res1},  {4'd0, e_res1});
    check("cout1", {4'd0, cout1}, {4'd0, e_cout1});
    check("vout1", {4'd0, vout1}, {4'd0, e_vout});
    check("res4",  {1'b0, res4},  {1'b0, e_res4});
    check("cout4", {4'd0, cout4}, {4'd0, e_cout4});
    check("vout4", {4'd0, vout4}, {4'd0, e_vout});
  endtask

  initial begin
    logic [4:0] v5;
    logic [3:0] ra, rb;
    logic [1:0] hold_f;

    rstn = 1'b0; vin = 1'b0; a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    cin = 1'b0; f1 = 1'b0; f0 = 1'b0;
    e_res1 = 1'b0; e_cout1 = 1'b0; e_res4 = 4'h0; e_cout4 = 1'b0; e_vout = 1'b0;

    // Reset held for 2 edges while a valid ADD is presented
    step(1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 2'b10);
    step(1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 2'b10);
    check("rst_all_zero", {cout4, res4}, 5'h00);
    check("rst_vout", {3'd0, vout1, vout4}, 5'h00);

    // Release: 1+1+0 -> res 0, carry 1
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 2'b10);
    check("rel_add1", {3'd0, cout1, res1}, 5'b00010);
    check("rel_vout", {4'd0, vout1}, 5'h01);

    // Exhaustive 1-bit sweep over A,B,CIN,F1,F0
    for (int i = 0; i < 32; i++) begin
      v5 = i[4:0];
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      step(1'b1, 1'b1, {ra[3:1], v5[4]}, {rb[3:1], v5[3]}, v5[2], v5[1:0]);
    end

    // Function-table examples with literal expectations ({cout,res})
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 2'b10);
    check("ex_add_111", {3'd0, cout1, res1}, 5'b00011);
    step(1'b1, 1'b1, 4'h1, 4'h0, 1'b1, 2'b10);
    check("ex_add_101", {3'd0, cout1, res1}, 5'b00010);
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 2'b11);
    check("ex_xor_111", {3'd0, cout1, res1}, 5'b00000);
    step(1'b1, 1'b1, 4'h0, 4'h1, 1'b1, 2'b00);
    check("ex_and_011", {3'd0, cout1, res1}, 5'b00000);

    // Hold: load a known result, then scramble inputs with VIN=0
    step(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, 2'b10);
    for (int i = 0; i < 6; i++) begin
      hold_f = 2'($urandom_range(0, 3));
      step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), hold_f);
    end
    check("hold_res4", {cout4, res4}, 5'b10000);
    check("hold_vout", {3'd0, vout1, vout4}, 5'h00);

    // Pipelined stream F=00,01,10,11 with A=B=1, CIN=0
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 2'b00);
    check("pipe0", {3'd0, cout1, res1}, 5'b00001);
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 2'b01);
    check("pipe1", {3'd0, cout1, res1}, 5'b00001);
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 2'b10);
    check("pipe2", {3'd0, cout1, res1}, 5'b00010);
    step(1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 2'b11);
    check("pipe3", {3'd0, cout1, res1}, 5'b00000);

    // WIDTH=4 ADD wrap cases
    step(1'b1, 1'b1, 4'hF, 4'h1, 1'b0, 2'b10);
    check("wrap_f_1", {cout4, res4}, 5'b10000);
    step(1'b1, 1'b1, 4'h7, 4'h8, 1'b1, 2'b10);
    check("wrap_7_8_c", {cout4, res4}, 5'b10000);
    step(1'b1, 1'b1, 4'h6, 4'h3, 1'b1, 2'b10);
    check("add4_6_3_c", {cout4, res4}, 5'b01010);

    // Reset mid-stream with VIN=1: sample must be discarded
    step(1'b1, 1'b1, 4'hA, 4'h5, 1'b0, 2'b01);
    check("pre_rst_or", {cout4, res4}, 5'b01111);
    step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 2'b10);
    check("mid_rst", {vout4, cout4, res4[2:0]}, 5'b00000);
    step(1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 2'b10);
    check("post_rst_hold", {cout4, res4}, 5'b00000);

    // Randomized traffic with occasional reset and idle cycles
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_1bit.md
Name: alu_1bit

Overview:
- Bit-slice ALU: combines operands A and B under a 2-bit function select (F1,F0): AND, OR, ADD with carry-in, XOR.
- Result RES and carry-out COUT are registered, one clock of latency.
- Default WIDTH=1 gives the single-bit slice. Larger WIDTH builds an internal ripple chain of identical slices.
- Sits in the datapath as the basic arithmetic/logic element driven by a stimulus/control block.

Parameters:
- WIDTH, 1, operand/result width in bits. Legal range 1..32.

Ports:
- CLK   input   1      rising-edge clock
- RSTN  input   1      synchronous active-low reset
- A     input   WIDTH  operand A
- B     input   WIDTH  operand B
- CIN   input   1      carry-in, used by ADD only
- F1    input   1      function select, MSB
- F0    input   1      function select, LSB
- VIN   input   1      input valid; inputs are sampled only when VIN=1
- RES   output  WIDTH  registered result
- COUT  output  1      registered carry-out
- VOUT  output  1      result valid, registered copy of VIN

Behaviour:
- Clock and reset:
  - Single clock domain, all state updates on the rising edge of CLK.
  - Reset is synchronous: RSTN=0 at a rising edge forces RES=0, COUT=0, VOUT=0, overriding everything else.
  - RSTN is sampled at the edge only; no asynchronous path.
- Function select {F1,F0}:
  - 00 AND: RES = A & B, COUT = 0.
  - 01 OR: RES = A | B, COUT = 0.
  - 10 ADD: per bit, sum = a ^ b ^ c and carry = (a&b) | (a&c) | (b&c).
    - Bit 0 carry-in is CIN; each later bit takes the previous bit's carry.
    - RES = sum bits; COUT = carry out of bit WIDTH-1.
    - Equivalent to {COUT,RES} = A + B + CIN, modulo 2^(WIDTH+1).
  - 11 XOR: RES = A ^ B, COUT = 0.
  - CIN is ignored by every function except ADD.
- Timing:
  - When RSTN=1 and VIN=1 at a rising edge, RES and COUT load the combinational result of the current A, B, CIN, F1, F0.
  - Latency is exactly 1 cycle.
  - VOUT <= VIN on every non-reset edge.
  - When VIN=0, RES and COUT hold their previous values and VOUT goes to 0 the next cycle.
- Back-to-back inputs:
  - Every cycle with VIN=1 produces a new result; throughput is 1 per cycle.
  - No backpressure and no handshake beyond valid.
- Boundary and reset cases:
  - Overflow in ADD wraps: RES takes the low WIDTH bits and COUT carries the overflow bit.
  - No saturation and no overflow flag.
  - Reset asserted in the same cycle as VIN=1: reset wins, and the sample is discarded.
  - Inputs X or unchanged while VIN=0 have no effect on the outputs.
- Implementation constraints:
  - No latches.
  - The combinational path from inputs to the register D pins must be fully defined for all 4 select codes.

Test Plan:
- Reset: RSTN=0 for 2 edges with VIN=1, A=1, B=1, F=10 -> RES=0, COUT=0, VOUT=0. Release RSTN -> VOUT=1 and RES/COUT update on the next edge.
- Exhaustive 1-bit sweep (WIDTH=1): all 32 combinations of A,B,CIN,F1,F0 with VIN=1 -> one cycle later RES/COUT match the function table. Examples:
  - A=1, B=1, CIN=1, F=10 -> RES=1, COUT=1.
  - A=1, B=0, CIN=1, F=10 -> RES=0, COUT=1.
  - A=1, B=1, CIN=1, F=11 -> RES=0, COUT=0.
  - A=0, B=1, CIN=1, F=00 -> RES=0, COUT=0.
- Hold: set VIN=0 and change A/B/F freely -> RES/COUT keep their last values and VOUT=0 one cycle later.
- Pipelined stream: VIN=1 for 4 consecutive cycles with F=00, 01, 10, 11, A=1, B=1, CIN=0 -> RES sequence 1, 1, 0, 0 and COUT sequence 0, 0, 1, 0, each one cycle after its input.
- WIDTH=4 ADD wrap: A=4'hF, B=4'h1, CIN=0, F=10 -> RES=4'h0, COUT=1. A=4'h7, B=4'h8, CIN=1 -> RES=4'h0, COUT=1.
- Reset mid-stream: RSTN=0 asserted on a cycle with VIN=1 -> the outputs read 0 next cycle and that sample never appears on RES.
